// File: rtl/snn_config_sequencer_if.sv
// Bus bundle for snn_config_sequencer: configuration load, spike handshake,
// network configuration outputs and result capture.
interface snn_config_sequencer_if;
  // configuration load
  logic         load_mode;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         cfg_done;
  // network configuration
  logic [255:0] weights;
  logic [511:0] delays;
  logic [4:0]   threshold;
  logic [2:0]   decay;
  logic [4:0]   refractory_period;
  // spike handshake and network control
  logic         spike_valid;
  logic [7:0]   spike_in;
  logic         spike_ready;
  logic [7:0]   input_spikes;
  logic         enable;
  logic         delay_clk;
  // result capture
  logic         output_data_ready;
  logic [7:0]   output_spikes;
  logic [7:0]   result;
  logic         result_valid;
  logic         timeout_err;

  modport master (
    output load_mode, data_in, data_valid, spike_valid, spike_in,
           output_data_ready, output_spikes,
    input  cfg_done, weights, delays, threshold, decay, refractory_period,
           spike_ready, input_spikes, enable, delay_clk, result, result_valid,
           timeout_err
  );

  modport slave (
    input  load_mode, data_in, data_valid, spike_valid, spike_in,
           output_data_ready, output_spikes,
    output cfg_done, weights, delays, threshold, decay, refractory_period,
           spike_ready, input_spikes, enable, delay_clk, result, result_valid,
           timeout_err
  );
endinterface

// File: rtl/snn_config_sequencer.sv
// Loads the 98-byte SNN configuration, then runs one spike vector at a time
// through the network. Optional RUN watchdog is enabled by SNN_SEQ_TIMEOUT_EN.
module snn_config_sequencer #(
  parameter int DELAY_DIV   = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                   clk,
  input logic                   reset,
  snn_config_sequencer_if.slave bus
);

  if (DELAY_DIV < 2 || DELAY_DIV > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("snn_config_sequencer: DELAY_DIV or TIMEOUT_CYC out of range");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [6:0] LAST_BYTE = 7'd97;
  localparam logic [7:0] DIV_LAST  = 8'(DELAY_DIV - 1);

  logic [1:0]   state;
  logic [6:0]   ptr;
  logic [5:0]   dly_idx;
  logic [7:0]   div_cnt;
  logic         run_timeout;

  logic [255:0] weights_q;
  logic [511:0] delays_q;
  logic [4:0]   threshold_q;
  logic [2:0]   decay_q;
  logic [4:0]   refractory_q;
  logic         cfg_done_q;
  logic         enable_q;
  logic [7:0]   input_spikes_q;
  logic [7:0]   result_q;
  logic         result_valid_q;

  assign dly_idx = 6'(ptr - 7'd32);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the configuration registers feed the network directly, so they
      // are cleared like any control flop rather than left as uninitialised storage.
      state          <= ST_IDLE;
      ptr            <= '0;
      weights_q      <= '0;
      delays_q       <= '0;
      threshold_q    <= '0;
      decay_q        <= '0;
      refractory_q   <= '0;
      cfg_done_q     <= 1'b0;
      enable_q       <= 1'b0;
      input_spikes_q <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      // NOTE: default-low assignment turns result_valid into a one-cycle strobe.
      result_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.load_mode) begin
            state <= ST_LOAD;
            ptr   <= '0;
          end
        end
        ST_LOAD: begin
          // The final byte completes the load even if load_mode drops with it.
          if (bus.data_valid && ptr == LAST_BYTE) begin
            threshold_q <= bus.data_in[4:0];
            cfg_done_q  <= 1'b1;
            ptr         <= '0;
            state       <= ST_READY;
          end else if (!bus.load_mode) begin
            ptr        <= '0;
            cfg_done_q <= 1'b0;
            state      <= ST_IDLE;
          end else if (bus.data_valid) begin
            if (ptr < 7'd32)
              weights_q[{ptr[4:0], 3'b000} +: 8] <= bus.data_in;
            else if (ptr < 7'd96)
              delays_q[{dly_idx, 3'b000} +: 8] <= bus.data_in;
            else
              {refractory_q, decay_q} <= bus.data_in;
            ptr <= ptr + 7'd1;
          end
        end
        ST_READY: begin
          if (bus.load_mode) begin
            cfg_done_q <= 1'b0;
            ptr        <= '0;
            state      <= ST_LOAD;
          end else if (bus.spike_valid) begin
            input_spikes_q <= bus.spike_in;
            enable_q       <= 1'b1;
            state          <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.output_data_ready) begin
            result_q       <= bus.output_spikes;
            result_valid_q <= 1'b1;
            enable_q       <= 1'b0;
            state          <= ST_READY;
          end else if (run_timeout) begin
            enable_q <= 1'b0;
            state    <= ST_READY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Held at zero outside RUN so every RUN starts with a fresh tick phase.
  always_ff @(posedge clk) begin
    if (reset || state != ST_RUN)
      div_cnt <= '0;
    else if (div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 8'd1;
  end

`ifdef SNN_SEQ_TIMEOUT_EN
  logic [15:0] run_cnt;
  logic        timeout_q;

  always_ff @(posedge clk) begin
    if (reset || state != ST_RUN)
      run_cnt <= '0;
    else
      run_cnt <= run_cnt + 16'd1;
  end

  // Fires in RUN cycle TIMEOUT_CYC; a result arriving that cycle still wins.
  assign run_timeout = (state == ST_RUN) && (run_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset)
      timeout_q <= 1'b0;
    else if (run_timeout && !bus.output_data_ready)
      timeout_q <= 1'b1;
  end

  assign bus.timeout_err = timeout_q;
`else
  assign run_timeout     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.cfg_done          = cfg_done_q;
  assign bus.weights           = weights_q;
  assign bus.delays            = delays_q;
  assign bus.threshold         = threshold_q;
  assign bus.decay             = decay_q;
  assign bus.refractory_period = refractory_q;
  assign bus.spike_ready       = (state == ST_READY);
  assign bus.input_spikes      = input_spikes_q;
  assign bus.enable            = enable_q;
  assign bus.delay_clk         = (state == ST_RUN) && (div_cnt == DIV_LAST);
  assign bus.result            = result_q;
  assign bus.result_valid      = result_valid_q;

endmodule

// File: tb/tb_snn_config_sequencer.sv
// Scoreboard bench for snn_config_sequencer: directed stimulus pushes expected
// configurations, results and delay_clk positions; a negedge monitor pops them.
module tb_snn_config_sequencer;

`ifdef SNN_SEQ_TIMEOUT_EN
  localparam int TCYC = 20;
`else
  localparam int TCYC = 1023;
`endif
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snn_config_sequencer_if bus ();

  snn_config_sequencer #(.DELAY_DIV(DIV), .TIMEOUT_CYC(TCYC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [255:0] w;
    logic [511:0] d;
    logic [4:0]   thr;
    logic [2:0]   dec;
    logic [4:0]   refr;
  } cfg_t;

  cfg_t       cfg_q[$];
  logic [7:0] res_q[$];
  int         pulse_q[$];

  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;
  int   run_cyc = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes equal to their index: byte 96 = 0x60 -> refr 0x0C/decay 0, byte 97 = 0x61 -> thr 1.
  function automatic cfg_t index_cfg();
    cfg_t c;
    for (int k = 0; k < 32; k++) c.w[8*k +: 8] = 8'(k);
    for (int k = 0; k < 64; k++) c.d[8*k +: 8] = 8'(32 + k);
    c.refr = 5'h0C;
    c.dec  = 3'd0;
    c.thr  = 5'h01;
    return c;
  endfunction

  function automatic cfg_t ones_cfg();
    cfg_t c;
    c.w    = '1;
    c.d    = '1;
    c.refr = 5'h1F;
    c.dec  = 3'd7;
    c.thr  = 5'h1F;
    return c;
  endfunction

  // Monitor: compares DUT events against the queues filled by the stimulus.
  initial begin
    cfg_t       c;
    logic [7:0] r;
    int         p;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        run_cyc   = 0;
      end else begin
        run_cyc = bus.enable ? run_cyc + 1 : 0;
        if (bus.delay_clk) begin
          if (pulse_q.size() == 0) check("delay_clk_unexpected", bus.delay_clk, 0);
          else begin
            p = pulse_q.pop_front();
            check("delay_clk_run_cycle", run_cyc, p);
          end
        end
        if (bus.cfg_done && !prev_done) begin
          if (cfg_q.size() == 0) check("cfg_done_unexpected", bus.cfg_done, 0);
          else begin
            c = cfg_q.pop_front();
            check("cfg_weights", bus.weights, c.w);
            check("cfg_delays", bus.delays, c.d);
            check("cfg_threshold", bus.threshold, c.thr);
            check("cfg_decay", bus.decay, c.dec);
            check("cfg_refractory", bus.refractory_period, c.refr);
          end
        end
        prev_done = bus.cfg_done;
        if (bus.result_valid) begin
          if (res_q.size() == 0) check("result_valid_unexpected", bus.result_valid, 0);
          else begin
            r = res_q.pop_front();
            check("result_value", bus.result, r);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset                 = 1'b1;
    bus.load_mode         = 1'b0;
    bus.data_in           = '0;
    bus.data_valid        = 1'b0;
    bus.spike_valid       = 1'b0;
    bus.spike_in          = '0;
    bus.output_data_ready = 1'b0;
    bus.output_spikes     = '0;
    repeat (2) tick();
    reset = 1'b0;

    // reset state
    check("rst_cfg_done", bus.cfg_done, 0);
    check("rst_weights", bus.weights, 0);
    check("rst_delays", bus.delays, 0);
    check("rst_params", {bus.threshold, bus.decay, bus.refractory_period}, 0);
    check("rst_spike_ready", bus.spike_ready, 0);
    check("rst_enable", bus.enable, 0);
    check("rst_delay_clk", bus.delay_clk, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_spikes_result", {bus.input_spikes, bus.result}, 0);

    // load bytes 0..97 with gaps in data_valid
    cfg_q.push_back(index_cfg());
    bus.load_mode = 1'b1;
    tick();
    for (int i = 0; i < 98; i++) begin
      if (i == 97) check("cfg_done_before_last", bus.cfg_done, 0);
      bus.data_in    = 8'(i);
      bus.data_valid = 1'b1;
      tick();
      if (i % 3 == 2) begin
        bus.data_in    = 8'hEE;
        bus.data_valid = 1'b0;
        tick();
      end
    end
    bus.data_valid = 1'b0;
    check("cfg_done_after_last", bus.cfg_done, 1);
    check("ready_after_load", bus.spike_ready, 1);
    check("weights_lo", bus.weights[7:0], 8'h00);
    check("weights_hi", bus.weights[255:248], 8'h1F);
    check("delays_lo", bus.delays[7:0], 8'h20);
    check("delays_hi", bus.delays[511:504], 8'h5F);
    check("decay_idx", bus.decay, 3'd0);
    check("refr_idx", bus.refractory_period, 5'h0C);
    check("thr_idx", bus.threshold, 5'h01);

    // load_mode still high in READY: reload begins, then aborts after 10 bytes
    tick();
    check("reload_clears_done", bus.cfg_done, 0);
    check("load_no_spike_ready", bus.spike_ready, 0);
    for (int i = 0; i < 10; i++) begin
      bus.data_in    = 8'hEE;
      bus.data_valid = 1'b1;
      tick();
    end
    bus.data_valid = 1'b0;
    bus.load_mode  = 1'b0;
    tick();
    check("abort_cfg_done", bus.cfg_done, 0);
    check("abort_written_kept", bus.weights[79:0], {10{8'hEE}});
    check("abort_old_kept", bus.weights[87:80], 8'h0A);
    check("idle_spike_ready", bus.spike_ready, 0);

    // IDLE ignores spikes and results
    bus.spike_valid       = 1'b1;
    bus.spike_in          = 8'h55;
    bus.output_data_ready = 1'b1;
    bus.output_spikes     = 8'h99;
    repeat (2) tick();
    check("idle_enable", bus.enable, 0);
    check("idle_spikes_result", {bus.input_spikes, bus.result}, 0);
    bus.spike_valid       = 1'b0;
    bus.output_data_ready = 1'b0;

    // reload all 0xFF, load_mode dropped together with the last byte
    cfg_q.push_back(ones_cfg());
    bus.load_mode = 1'b1;
    tick();
    for (int i = 0; i < 98; i++) begin
      bus.data_in    = 8'hFF;
      bus.data_valid = 1'b1;
      if (i == 97) bus.load_mode = 1'b0;
      tick();
    end
    bus.data_valid = 1'b0;
    check("ff_cfg_done", bus.cfg_done, 1);
    check("ff_weights", bus.weights, {256{1'b1}});
    check("ff_delays", bus.delays, {512{1'b1}});
    check("ff_params", {bus.threshold, bus.decay, bus.refractory_period}, 13'h1FFF);

    // spike run: pulses in RUN cycles 4 and 8, result in cycle 10
    check("spike_ready_ready", bus.spike_ready, 1);
    pulse_q.push_back(4);
    pulse_q.push_back(8);
    res_q.push_back(8'h3C);
    bus.spike_in    = 8'hA5;
    bus.spike_valid = 1'b1;
    tick();
    bus.spike_valid = 1'b0;
    bus.spike_in    = 8'h00;
    check("run_enable", bus.enable, 1);
    check("run_input_spikes", bus.input_spikes, 8'hA5);
    check("run_spike_ready", bus.spike_ready, 0);
    for (int c = 1; c < 10; c++) begin
      if (c == 5) bus.load_mode = 1'b1;
      if (c == 6) begin
        bus.spike_valid = 1'b1;
        bus.spike_in    = 8'h11;
      end
      if (c == 7) bus.spike_valid = 1'b0;
      if (c == 8) bus.load_mode = 1'b0;
      tick();
    end
    check("run10_enable", bus.enable, 1);
    check("run10_spikes_held", bus.input_spikes, 8'hA5);
    check("run_load_ignored", bus.cfg_done, 1);
    bus.output_data_ready = 1'b1;
    bus.output_spikes     = 8'h3C;
    tick();
    bus.output_data_ready = 1'b0;
    bus.output_spikes     = 8'h00;
    check("done_result", bus.result, 8'h3C);
    check("done_result_valid", bus.result_valid, 1);
    check("done_enable", bus.enable, 0);
    check("done_delay_clk", bus.delay_clk, 0);
    check("done_spike_ready", bus.spike_ready, 1);
    tick();
    check("result_valid_single", bus.result_valid, 0);
    check("result_hold", bus.result, 8'h3C);

    // output_data_ready outside RUN is ignored
    bus.output_data_ready = 1'b1;
    bus.output_spikes     = 8'h77;
    tick();
    bus.output_data_ready = 1'b0;
    check("ready_odr_ignored", bus.result, 8'h3C);

    // load_mode beats spike_valid in READY
    bus.load_mode   = 1'b1;
    bus.spike_valid = 1'b1;
    bus.spike_in    = 8'h81;
    tick();
    bus.spike_valid = 1'b0;
    check("prio_enable", bus.enable, 0);
    check("prio_cfg_done", bus.cfg_done, 0);
    check("prio_spike_ready", bus.spike_ready, 0);
    check("prio_spikes_kept", bus.input_spikes, 8'hA5);
    cfg_q.push_back(index_cfg());
    for (int i = 0; i < 98; i++) begin
      bus.data_in    = 8'(i);
      bus.data_valid = 1'b1;
      if (i == 97) bus.load_mode = 1'b0;
      tick();
    end
    bus.data_valid = 1'b0;
    check("reload_cfg_done", bus.cfg_done, 1);

    // RUN without a network result
`ifdef SNN_SEQ_TIMEOUT_EN
    for (int c = DIV; c <= TCYC; c += DIV) pulse_q.push_back(c);
    bus.spike_in    = 8'h0F;
    bus.spike_valid = 1'b1;
    tick();
    bus.spike_valid = 1'b0;
    repeat (TCYC - 1) tick();
    check("to_last_enable", bus.enable, 1);
    check("to_last_err", bus.timeout_err, 0);
    tick();
    check("to_enable", bus.enable, 0);
    check("to_err", bus.timeout_err, 1);
    check("to_no_result_valid", bus.result_valid, 0);
    check("to_spike_ready", bus.spike_ready, 1);
    check("to_result_kept", bus.result, 8'h3C);
    res_q.push_back(8'h5A);
    bus.spike_valid = 1'b1;
    tick();
    bus.spike_valid = 1'b0;
    tick();
    bus.output_data_ready = 1'b1;
    bus.output_spikes     = 8'h5A;
    tick();
    bus.output_data_ready = 1'b0;
    check("to_next_result", bus.result, 8'h5A);
    check("to_err_sticky", bus.timeout_err, 1);
`else
    for (int c = DIV; c <= 1000; c += DIV) pulse_q.push_back(c);
    bus.spike_in    = 8'h0F;
    bus.spike_valid = 1'b1;
    tick();
    bus.spike_valid = 1'b0;
    repeat (999) tick();
    check("wait_enable", bus.enable, 1);
    check("wait_no_err", bus.timeout_err, 0);
    check("wait_spikes", bus.input_spikes, 8'h0F);
    res_q.push_back(8'hC3);
    bus.output_data_ready = 1'b1;
    bus.output_spikes     = 8'hC3;
    tick();
    bus.output_data_ready = 1'b0;
    check("wait_result", bus.result, 8'hC3);
    check("wait_enable_off", bus.enable, 0);
    check("wait_err_off", bus.timeout_err, 0);
`endif

    // reset in RUN cycle 3
    bus.spike_in    = 8'hE7;
    bus.spike_valid = 1'b1;
    tick();
    bus.spike_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_enable", bus.enable, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_enable", bus.enable, 0);
    check("mid_rst_spikes", bus.input_spikes, 0);
    check("mid_rst_weights", bus.weights, 0);
    check("mid_rst_delays", bus.delays, 0);
    check("mid_rst_cfg_done", bus.cfg_done, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_err", bus.timeout_err, 0);
    check("mid_rst_spike_ready", bus.spike_ready, 0);
    bus.spike_valid = 1'b1;
    bus.spike_in    = 8'h3C;
    repeat (2) tick();
    bus.spike_valid = 1'b0;
    check("post_rst_idle", bus.enable, 0);
    repeat (3) tick();

    check("cfg_q_drained", cfg_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    check("pulse_q_drained", pulse_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_config_sequencer.md
SNN_CONFIG_SEQUENCER -- requirements
Module: snn_config_sequencer

Interface
REQ-001 SHALL have parameter DELAY_DIV, default 4, clk cycles per delay_clk pulse (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, maximum RUN cycles before abort (legal range 1..65535).
REQ-003 SHALL have ports:
- clk  in  1  the block's single clock.
- reset  in  1  synchronous, active-high reset.
- load_mode  in  1  request configuration load.
- data_in  in  8  configuration byte.
- data_valid  in  1  data_in qualifier.
- cfg_done  out  1  all 98 configuration bytes loaded.
- weights  out  256  network weight bus.
- delays  out  512  network delay bus.
- threshold  out  5  firing threshold.
- decay  out  3  decay value.
- refractory_period  out  5  refractory period.
- spike_valid  in  1  input spike vector offered.
- spike_in  in  8  input spike vector.
- spike_ready  out  1  vector accepted this cycle when spike_valid is also high.
- input_spikes  out  8  spikes driven to the network.
- enable  out  1  network enable.
- delay_clk  out  1  one-cycle delay tick.
- output_data_ready  in  1  network result-ready flag.
- output_spikes  in  8  network layer-2 spikes.
- result  out  8  captured output spikes.
- result_valid  out  1  one-cycle result strobe.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, READY, RUN.
REQ-005 IDLE: load_mode=1 -> LOAD, byte pointer=0; all other inputs ignored.
REQ-006 LOAD: each cycle with data_valid=1 SHALL write data_in to the byte at the pointer and increment the pointer.
REQ-007 Byte map: bytes 0-31 -> weights[8k+7:8k]; bytes 32-95 -> delays[8(k-32)+7:8(k-32)]; byte 96 -> {refractory_period, decay}; byte 97 -> threshold = data_in[4:0], with data_in[7:5] ignored.
REQ-008 Writing byte 97 SHALL set cfg_done=1 on the next cycle and move to READY, regardless of load_mode.
REQ-009 load_mode=0 in LOAD before byte 97 SHALL abort to IDLE with pointer=0 and cfg_done=0; bytes already written are retained.
REQ-010 READY: spike_ready=1. spike_valid=1 SHALL latch spike_in into input_spikes, set enable=1 and enter RUN on the next cycle.
REQ-011 READY with load_mode=1 SHALL clear cfg_done and enter LOAD with pointer=0. If spike_valid is also high, load_mode wins and the spike is not accepted.
REQ-012 spike_ready SHALL be 0 outside READY; spike_valid SHALL be ignored outside READY.
REQ-013 RUN: enable=1 and input_spikes are held.
REQ-014 RUN: the divider counter SHALL reset to 0 on RUN entry. delay_clk=1 for exactly one cycle when the counter equals DELAY_DIV-1; the counter then wraps to 0. The first pulse occurs in RUN cycle DELAY_DIV.
REQ-015 RUN: the first cycle with output_data_ready=1 SHALL, on the next edge:
- capture output_spikes into result;
- pulse result_valid for one cycle;
- clear enable and delay_clk;
- return to READY.
REQ-016 output_data_ready SHALL be ignored outside RUN; result SHALL hold until the next capture.
REQ-017 load_mode SHALL be ignored in RUN.

Reset
REQ-018 reset=1 SHALL, at the next clk edge:
- force IDLE;
- clear pointer, divider and timeout counters;
- zero weights, delays, threshold, decay, refractory_period, input_spikes and result;
- drive cfg_done, spike_ready, enable, delay_clk, result_valid and timeout_err to 0.
REQ-019 reset asserted mid-LOAD or mid-RUN SHALL take precedence over every other input in that cycle.

Configuration
REQ-020 Macro SNN_SEQ_TIMEOUT_EN defined: a RUN-cycle counter starting at 0 on RUN entry is included. Reaching TIMEOUT_CYC without output_data_ready SHALL:
- set timeout_err=1 (sticky until reset);
- clear enable;
- return to READY without result_valid.
REQ-021 Macro SNN_SEQ_TIMEOUT_EN undefined: no counter is built, timeout_err is tied 0, and RUN waits indefinitely.

Verification
REQ-022 Load bytes 0x00..0x61 (values equal to index) with gaps in data_valid -> cfg_done=1 one cycle after byte 97. Required values: weights[7:0]=0x00, weights[255:248]=0x1F, delays[7:0]=0x20, delays[511:504]=0x5F, decay=0, refractory_period=0x0C, threshold=0x01.
REQ-023 Drop load_mode after 10 bytes -> state IDLE, cfg_done=0. Reload 98 bytes of 0xFF -> all weight/delay bits 1, threshold=0x1F, decay=7, refractory_period=0x1F.
REQ-024 In READY, spike_in=0xA5 with spike_valid=1, DELAY_DIV=4, output_data_ready raised in RUN cycle 10 with output_spikes=0x3C:
- input_spikes=0xA5 while enable=1;
- delay_clk pulses in RUN cycles 4 and 8;
- result=0x3C with a single result_valid pulse;
- spike_ready=1 again.
REQ-025 In READY, load_mode=1 and spike_valid=1 in the same cycle -> LOAD entered, enable stays 0, cfg_done=0.
REQ-026 With SNN_SEQ_TIMEOUT_EN and TIMEOUT_CYC=20, never raise output_data_ready -> enable falls after 20 RUN cycles, timeout_err=1, result_valid never pulses. Without the macro -> enable still 1 after 1000 cycles, timeout_err=0.
REQ-027 Assert reset during RUN cycle 3 -> next cycle: enable=0, input_spikes=0, weights=0, cfg_done=0, state IDLE.
